// File: rtl/sweep_acq_ctrl.sv
// sweep_acq_ctrl
//
// Sequencer for the sweep-acquisition mode of the mode switcher. Each DAC
// code from StartDac to EndDac (inclusive, stepping by DacStep) is handled
// in the same order:
//   1. request a slow-control load and wait for the configuration to land;
//   2. emit a header word;
//   3. run an acquisition and forward a fixed number of ParallelData words;
//   4. pulse a force-reset, then settle.
// A trailer word closes the sweep and SweepAcqDone is then held.
//
// Ports
//   Clk, reset_n                      clock, asynchronous active-low reset
//   SweepStart                        level: high runs the sweep, low aborts/idles
//   StartDac/EndDac/DacStep           sweep range and increment (step 0 acts as 1)
//   MaxWordCount                      words forwarded per DAC point
//   SCConfigDone                      pulse: SC parameters are in the chip
//   ParallelData/_en                  acquisition stream from the switcher
//   SweepAcq10BitDac                  current DAC code
//   SweepAcqMicrorocSCParameterLoad   one-cycle SC load request
//   SweepAcqMicrorocAcqStartStop      acquisition enable
//   SweepAcqSingleDacDone             one-cycle force-reset at end of a point
//   SweepAcqData/_en                  word stream to the USB FIFO
//   SweepTestUsbStartStop             USB transfer enable for the whole sweep
//   SweepAcqDone                      sweep complete (level)
module sweep_acq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SC_TIMEOUT    = 1000,
  parameter logic [5:0]  HEADER_TAG    = 6'b111100,
  parameter logic [15:0] TRAILER_WORD  = 16'hFF45
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        SweepStart,
  input  logic [9:0]  StartDac,
  input  logic [9:0]  EndDac,
  input  logic [9:0]  DacStep,
  input  logic [15:0] MaxWordCount,
  input  logic        SCConfigDone,
  input  logic [15:0] ParallelData,
  input  logic        ParallelData_en,
  output logic [9:0]  SweepAcq10BitDac,
  output logic        SweepAcqMicrorocSCParameterLoad,
  output logic        SweepAcqMicrorocAcqStartStop,
  output logic        SweepAcqSingleDacDone,
  output logic [15:0] SweepAcqData,
  output logic        SweepAcqData_en,
  output logic        SweepTestUsbStartStop,
  output logic        SweepAcqDone
);

  // One timer serves both the SC wait and the settle interval, so it is
  // sized for whichever of the two is longer.
  localparam int unsigned TIMER_MAX = (SC_TIMEOUT > SETTLE_CYCLES) ? SC_TIMEOUT : SETTLE_CYCLES;
  localparam int          TW        = $clog2(TIMER_MAX + 1);
  localparam logic [TW-1:0] SC_LAST     = TW'(SC_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_SC,
    S_WAIT_SC,
    S_HEADER,
    S_ACQ,
    S_DAC_DONE,
    S_SETTLE,
    S_NEXT,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [9:0]    dac_q;
  logic [9:0]    endDac_q;
  logic [9:0]    step_q;
  logic [15:0]   maxWords_q;
  logic [15:0]   wordCount_q;
  logic [TW-1:0] timer_q;
  logic          scLoad_q;
  logic          acqRun_q;
  logic          dacDone_q;
  logic [15:0]   data_q;
  logic          dataEn_q;
  logic          usbRun_q;
  logic          sweepDone_q;

  logic [10:0]   nextSum_d;
  logic [16:0]   wordCountInc_d;
  logic          accept_d;

  // Next DAC code is computed one bit wider so a step past 1023 is seen
  // as leaving the range rather than wrapping back to a low code.
  always_comb begin
    nextSum_d      = {1'b0, dac_q} + {1'b0, step_q};
    wordCountInc_d = {1'b0, wordCount_q} + 17'd1;
    accept_d       = ParallelData_en && (wordCount_q < maxWords_q);
  end

  // Sequencer. Every output is a register written on the edge that enters
  // the state it belongs to, so outputs line up with the state they describe.
  // Pulse-type outputs default low each cycle.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dac_q       <= '0;
      endDac_q    <= '0;
      step_q      <= '0;
      maxWords_q  <= '0;
      wordCount_q <= '0;
      timer_q     <= '0;
      scLoad_q    <= 1'b0;
      acqRun_q    <= 1'b0;
      dacDone_q   <= 1'b0;
      data_q      <= '0;
      dataEn_q    <= 1'b0;
      usbRun_q    <= 1'b0;
      sweepDone_q <= 1'b0;
    end else begin
      scLoad_q  <= 1'b0;
      dacDone_q <= 1'b0;
      dataEn_q  <= 1'b0;
      data_q    <= '0;

      if (!SweepStart && state_q != S_IDLE && state_q != S_DONE) begin
        // Abort: drop everything, including any word arriving this cycle.
        state_q     <= S_IDLE;
        dac_q       <= '0;
        wordCount_q <= '0;
        timer_q     <= '0;
        acqRun_q    <= 1'b0;
        usbRun_q    <= 1'b0;
        sweepDone_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (SweepStart) begin
              endDac_q    <= EndDac;
              step_q      <= (DacStep == 10'd0) ? 10'd1 : DacStep;
              maxWords_q  <= MaxWordCount;
              wordCount_q <= '0;
              timer_q     <= '0;
              usbRun_q    <= 1'b1;
              if (StartDac > EndDac) begin
                state_q  <= S_TRAILER;
                data_q   <= TRAILER_WORD;
                dataEn_q <= 1'b1;
              end else begin
                state_q  <= S_LOAD_SC;
                dac_q    <= StartDac;
                scLoad_q <= 1'b1;
              end
            end
          end

          S_LOAD_SC: begin
            timer_q <= '0;
            state_q <= S_WAIT_SC;
          end

          S_WAIT_SC: begin
            if (SCConfigDone || timer_q == SC_LAST) begin
              state_q  <= S_HEADER;
              timer_q  <= '0;
              data_q   <= {HEADER_TAG, dac_q};
              dataEn_q <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end

          S_HEADER: begin
            state_q     <= S_ACQ;
            acqRun_q    <= 1'b1;
            wordCount_q <= '0;
          end

          // Leave as soon as the last word is taken so no surplus word can
          // slip in; a zero word budget leaves after a single cycle.
          S_ACQ: begin
            if (wordCount_q == maxWords_q) begin
              state_q   <= S_DAC_DONE;
              acqRun_q  <= 1'b0;
              dacDone_q <= 1'b1;
            end else if (accept_d) begin
              data_q      <= ParallelData;
              dataEn_q    <= 1'b1;
              wordCount_q <= wordCountInc_d[15:0];
              if (wordCountInc_d == {1'b0, maxWords_q}) begin
                state_q   <= S_DAC_DONE;
                acqRun_q  <= 1'b0;
                dacDone_q <= 1'b1;
              end
            end
          end

          S_DAC_DONE: begin
            wordCount_q <= '0;
            timer_q     <= '0;
            state_q     <= S_SETTLE;
          end

          S_SETTLE: begin
            if (timer_q == SETTLE_LAST) begin
              timer_q <= '0;
              state_q <= S_NEXT;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end

          S_NEXT: begin
            if (nextSum_d[10] || nextSum_d > {1'b0, endDac_q}) begin
              state_q  <= S_TRAILER;
              data_q   <= TRAILER_WORD;
              dataEn_q <= 1'b1;
            end else begin
              state_q  <= S_LOAD_SC;
              dac_q    <= nextSum_d[9:0];
              scLoad_q <= 1'b1;
            end
          end

          S_TRAILER: begin
            state_q     <= S_DONE;
            sweepDone_q <= 1'b1;
            usbRun_q    <= 1'b0;
          end

          S_DONE: begin
            if (!SweepStart) begin
              state_q     <= S_IDLE;
              sweepDone_q <= 1'b0;
              dac_q       <= '0;
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign SweepAcq10BitDac                = dac_q;
  assign SweepAcqMicrorocSCParameterLoad = scLoad_q;
  assign SweepAcqMicrorocAcqStartStop    = acqRun_q;
  assign SweepAcqSingleDacDone           = dacDone_q;
  assign SweepAcqData                    = data_q;
  assign SweepAcqData_en                 = dataEn_q;
  assign SweepTestUsbStartStop           = usbRun_q;
  assign SweepAcqDone                    = sweepDone_q;

endmodule

// File: tb/tb_sweep_acq_ctrl.sv
// tb_sweep_acq_ctrl
//
// Bench for sweep_acq_ctrl. A responder plays the mode switcher: it answers
// each SC load with SCConfigDone after a chosen delay and offers random
// ParallelData words while acquisition is enabled. A monitor logs the USB
// stream, load pulses and force-reset pulses. A sweep-level model builds the
// expected DAC list and USB stream from the sweep settings and the words
// that were offered.
module tb_sweep_acq_ctrl;

  localparam int unsigned SC_TIMEOUT    = 1000;
  localparam int unsigned SETTLE_CYCLES = 16;
  localparam logic [5:0]  HEADER_TAG    = 6'b111100;
  localparam logic [15:0] TRAILER_WORD  = 16'hFF45;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SweepStart = 1'b0;
  logic [9:0]  StartDac = '0;
  logic [9:0]  EndDac = '0;
  logic [9:0]  DacStep = '0;
  logic [15:0] MaxWordCount = '0;
  logic        SCConfigDone = 1'b0;
  logic [15:0] ParallelData = '0;
  logic        ParallelData_en = 1'b0;
  logic [9:0]  SweepAcq10BitDac;
  logic        SweepAcqMicrorocSCParameterLoad;
  logic        SweepAcqMicrorocAcqStartStop;
  logic        SweepAcqSingleDacDone;
  logic [15:0] SweepAcqData;
  logic        SweepAcqData_en;
  logic        SweepTestUsbStartStop;
  logic        SweepAcqDone;

  int nCmp = 0;
  int nMis = 0;
  int cycle = 0;

  logic [15:0] usbQ[$];
  int          usbCyc[$];
  logic [9:0]  loadDac[$];
  int          loadCyc[$];
  int          doneCyc[$];
  logic [15:0] offWord[$];
  int          offPt[$];
  logic [15:0] expUsb[$];
  logic [9:0]  expLoad[$];

  int scDelay = -1;
  int scCount = 0;
  int enPct = 0;
  bit noise = 1'b0;
  int startCyc = 0;

  sweep_acq_ctrl #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SC_TIMEOUT(SC_TIMEOUT),
    .HEADER_TAG(HEADER_TAG),
    .TRAILER_WORD(TRAILER_WORD)
  ) dut (
    .Clk(Clk),
    .reset_n(reset_n),
    .SweepStart(SweepStart),
    .StartDac(StartDac),
    .EndDac(EndDac),
    .DacStep(DacStep),
    .MaxWordCount(MaxWordCount),
    .SCConfigDone(SCConfigDone),
    .ParallelData(ParallelData),
    .ParallelData_en(ParallelData_en),
    .SweepAcq10BitDac(SweepAcq10BitDac),
    .SweepAcqMicrorocSCParameterLoad(SweepAcqMicrorocSCParameterLoad),
    .SweepAcqMicrorocAcqStartStop(SweepAcqMicrorocAcqStartStop),
    .SweepAcqSingleDacDone(SweepAcqSingleDacDone),
    .SweepAcqData(SweepAcqData),
    .SweepAcqData_en(SweepAcqData_en),
    .SweepTestUsbStartStop(SweepTestUsbStartStop),
    .SweepAcqDone(SweepAcqDone)
  );

  // Free-running clock and a cycle index used to time events.
  always #5 Clk = ~Clk;

  always @(posedge Clk) cycle <= cycle + 1;

  // Monitor and switcher model, both on the falling edge so that DUT
  // outputs are stable and driven inputs settle before the next rising edge.
  always @(negedge Clk) begin
    if (SweepAcqData_en) begin
      usbQ.push_back(SweepAcqData);
      usbCyc.push_back(cycle);
    end
    if (SweepAcqMicrorocSCParameterLoad) begin
      loadDac.push_back(SweepAcq10BitDac);
      loadCyc.push_back(cycle);
    end
    if (SweepAcqSingleDacDone) doneCyc.push_back(cycle);

    SCConfigDone = 1'b0;
    if (SweepAcqMicrorocSCParameterLoad && scDelay >= 0) begin
      if (scDelay == 0) SCConfigDone = 1'b1;
      else scCount = scDelay;
    end else if (scCount > 0) begin
      scCount--;
      if (scCount == 0) SCConfigDone = 1'b1;
    end

    ParallelData_en = 1'b0;
    if (SweepAcqMicrorocAcqStartStop) begin
      if ($urandom_range(99) < enPct) begin
        ParallelData    = 16'($urandom);
        ParallelData_en = 1'b1;
        offWord.push_back(ParallelData);
        offPt.push_back(loadDac.size() - 1);
      end
    end else if (noise) begin
      ParallelData    = 16'($urandom);
      ParallelData_en = 1'b1;
    end
  end

  task automatic clearLogs();
    usbQ.delete(); usbCyc.delete(); loadDac.delete(); loadCyc.delete();
    doneCyc.delete(); offWord.delete(); offPt.delete();
    scCount = 0;
  endtask

  // Sweep-level reference: walk the DAC range, one header per point, the
  // first MaxWordCount words offered for that point, then the trailer.
  function automatic void buildExpected(input logic [9:0] s, input logic [9:0] e,
                                        input logic [9:0] st, input logic [15:0] mx);
    int stepV, d, n, p;
    expUsb.delete();
    expLoad.delete();
    stepV = (st == 10'd0) ? 1 : int'(st);
    d = int'(s);
    p = 0;
    while (d <= int'(e)) begin
      expLoad.push_back(10'(d));
      expUsb.push_back({HEADER_TAG, 10'(d)});
      n = 0;
      foreach (offWord[i]) begin
        if (offPt[i] == p && n < int'(mx)) begin
          expUsb.push_back(offWord[i]);
          n++;
        end
      end
      p++;
      d += stepV;
    end
    expUsb.push_back(TRAILER_WORD);
  endfunction

  // Starts a sweep and waits (bounded) for SweepAcqDone. With scramble set
  // the sweep inputs are randomised after the start edge.
  task automatic runSweep(input logic [9:0] s, input logic [9:0] e, input logic [9:0] st,
                          input logic [15:0] mx, input int delay, input int pct,
                          input bit scramble, output bit ok);
    clearLogs();
    scDelay = delay;
    enPct   = pct;
    @(negedge Clk);
    StartDac = s; EndDac = e; DacStep = st; MaxWordCount = mx;
    SweepStart = 1'b1;
    startCyc = cycle;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge Clk);
      if (SweepAcqDone) begin
        ok = 1'b1;
        break;
      end
      if (scramble) begin
        StartDac     = 10'($urandom_range(1023));
        EndDac       = 10'($urandom_range(1023));
        DacStep      = 10'($urandom_range(1023));
        MaxWordCount = 16'($urandom_range(65535));
      end
    end
  endtask

  task automatic endSweep();
    @(negedge Clk);
    SweepStart = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    #1;
    nCmp++;
    if ({SweepAcq10BitDac, SweepAcqMicrorocSCParameterLoad, SweepAcqMicrorocAcqStartStop,
         SweepAcqSingleDacDone, SweepAcqData, SweepAcqData_en, SweepTestUsbStartStop,
         SweepAcqDone} !== 33'd0) begin
      nMis++;
      $display("[TB] FAIL reset_outputs got dac=%0d data=%h en=%b usb=%b done=%b expected all 0",
               SweepAcq10BitDac, SweepAcqData, SweepAcqData_en, SweepTestUsbStartStop, SweepAcqDone);
    end
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic_sweep();
    bit ok;
    runSweep(10'd100, 10'd102, 10'd1, 16'd3, 5, 60, 1'b0, ok);
    buildExpected(10'd100, 10'd102, 10'd1, 16'd3);
    nCmp++;
    if (!ok) begin nMis++; $display("[TB] FAIL basic_done got timeout expected SweepAcqDone=1"); end
    nCmp++;
    if (SweepTestUsbStartStop !== 1'b0) begin
      nMis++; $display("[TB] FAIL basic_usb_at_done got %b expected 0", SweepTestUsbStartStop);
    end
    nCmp++;
    if (loadDac.size() != expLoad.size()) begin
      nMis++; $display("[TB] FAIL basic_load_count got %0d expected %0d", loadDac.size(), expLoad.size());
    end
    for (int i = 0; i < expLoad.size() && i < loadDac.size(); i++) begin
      nCmp++;
      if (loadDac[i] !== expLoad[i]) begin
        nMis++; $display("[TB] FAIL basic_load_dac[%0d] got %0d expected %0d", i, loadDac[i], expLoad[i]);
      end
      if (usbCyc.size() > i * 4) begin
        nCmp++;
        if (usbCyc[i * 4] - loadCyc[i] != 6) begin
          nMis++; $display("[TB] FAIL basic_header_latency[%0d] got %0d expected 6", i, usbCyc[i * 4] - loadCyc[i]);
        end
      end
    end
    nCmp++;
    if (usbQ.size() != expUsb.size()) begin
      nMis++; $display("[TB] FAIL basic_stream_len got %0d expected %0d", usbQ.size(), expUsb.size());
    end
    for (int i = 0; i < expUsb.size() && i < usbQ.size(); i++) begin
      nCmp++;
      if (usbQ[i] !== expUsb[i]) begin
        nMis++; $display("[TB] FAIL basic_stream[%0d] got %h expected %h", i, usbQ[i], expUsb[i]);
      end
    end
    nCmp++;
    if (doneCyc.size() != 3) begin
      nMis++; $display("[TB] FAIL basic_single_done got %0d expected 3", doneCyc.size());
    end
    @(negedge Clk);
    SweepStart = 1'b0;
    @(negedge Clk);
    nCmp++;
    if (SweepAcqDone !== 1'b0) begin
      nMis++; $display("[TB] FAIL basic_done_clear got %b expected 0", SweepAcqDone);
    end
    @(negedge Clk);
  endtask

  task automatic test_reversed_range();
    bit ok;
    runSweep(10'd5, 10'd3, 10'd1, 16'd2, 3, 100, 1'b0, ok);
    nCmp++;
    if (!ok || cycle - startCyc > 3) begin
      nMis++; $display("[TB] FAIL reversed_done_latency got %0d cycles (ok=%b) expected <=3", cycle - startCyc, ok);
    end
    nCmp++;
    if (loadDac.size() != 0) begin
      nMis++; $display("[TB] FAIL reversed_loads got %0d expected 0", loadDac.size());
    end
    nCmp++;
    if (usbQ.size() != 1 || usbQ[0] !== TRAILER_WORD) begin
      nMis++; $display("[TB] FAIL reversed_stream got %0d words first=%h expected 1 word %h",
                       usbQ.size(), (usbQ.size() > 0) ? usbQ[0] : 16'h0, TRAILER_WORD);
    end
    endSweep();
  endtask

  task automatic test_top_of_range();
    bit ok;
    runSweep(10'd1020, 10'd1023, 10'd2, 16'd2, 2, 70, 1'b0, ok);
    buildExpected(10'd1020, 10'd1023, 10'd2, 16'd2);
    nCmp++;
    if (!ok) begin nMis++; $display("[TB] FAIL top_done got timeout expected SweepAcqDone=1"); end
    nCmp++;
    if (loadDac.size() != 2 || loadDac[0] !== 10'd1020 || loadDac[1] !== 10'd1022) begin
      nMis++; $display("[TB] FAIL top_loads got count %0d expected 1020,1022", loadDac.size());
    end
    nCmp++;
    if (usbQ.size() != expUsb.size()) begin
      nMis++; $display("[TB] FAIL top_stream_len got %0d expected %0d", usbQ.size(), expUsb.size());
    end
    for (int i = 0; i < expUsb.size() && i < usbQ.size(); i++) begin
      nCmp++;
      if (usbQ[i] !== expUsb[i]) begin
        nMis++; $display("[TB] FAIL top_stream[%0d] got %h expected %h", i, usbQ[i], expUsb[i]);
      end
    end
    endSweep();
  endtask

  task automatic test_continuous();
    bit ok;
    noise = 1'b1;
    runSweep(10'd10, 10'd12, 10'd1, 16'd2, 4, 100, 1'b0, ok);
    buildExpected(10'd10, 10'd12, 10'd1, 16'd2);
    nCmp++;
    if (!ok) begin nMis++; $display("[TB] FAIL cont_done got timeout expected SweepAcqDone=1"); end
    nCmp++;
    if (usbQ.size() != expUsb.size()) begin
      nMis++; $display("[TB] FAIL cont_stream_len got %0d expected %0d", usbQ.size(), expUsb.size());
    end
    for (int i = 0; i < expUsb.size() && i < usbQ.size(); i++) begin
      nCmp++;
      if (usbQ[i] !== expUsb[i]) begin
        nMis++; $display("[TB] FAIL cont_stream[%0d] got %h expected %h", i, usbQ[i], expUsb[i]);
      end
    end
    for (int p = 0; p < doneCyc.size() && p * 3 + 2 < usbCyc.size(); p++) begin
      nCmp++;
      if (doneCyc[p] - usbCyc[p * 3 + 2] < 0 || doneCyc[p] - usbCyc[p * 3 + 2] > 1) begin
        nMis++; $display("[TB] FAIL cont_dac_done_gap[%0d] got %0d expected 0..1", p, doneCyc[p] - usbCyc[p * 3 + 2]);
      end
    end
    noise = 1'b0;
    endSweep();
  endtask

  task automatic test_abort();
    bit ok;
    int seen;
    clearLogs();
    scDelay = 3;
    enPct = 100;
    @(negedge Clk);
    StartDac = 10'd50; EndDac = 10'd52; DacStep = 10'd1; MaxWordCount = 16'd4;
    SweepStart = 1'b1;
    seen = 0;
    for (int i = 0; i < 300 && seen < 2; i++) begin
      @(negedge Clk);
      if (SweepAcqData_en) seen++;
    end
    nCmp++;
    if (seen != 2) begin nMis++; $display("[TB] FAIL abort_first_word got %0d words expected 2", seen); end
    SweepStart = 1'b0;
    @(negedge Clk);
    nCmp++;
    if ({SweepAcqMicrorocAcqStartStop, SweepTestUsbStartStop, SweepAcqData_en, SweepAcqDone} !== 4'b0000) begin
      nMis++; $display("[TB] FAIL abort_outputs got acq=%b usb=%b en=%b done=%b expected 0000",
                       SweepAcqMicrorocAcqStartStop, SweepTestUsbStartStop, SweepAcqData_en, SweepAcqDone);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (SweepAcqData_en || SweepAcqDone || SweepAcqMicrorocSCParameterLoad) seen++;
    end
    nCmp++;
    if (seen != 0) begin nMis++; $display("[TB] FAIL abort_quiet got %0d active cycles expected 0", seen); end
    runSweep(10'd200, 10'd201, 10'd1, 16'd4, 2, 80, 1'b0, ok);
    buildExpected(10'd200, 10'd201, 10'd1, 16'd4);
    nCmp++;
    if (!ok || loadDac.size() == 0 || loadDac[0] !== 10'd200) begin
      nMis++; $display("[TB] FAIL abort_restart got ok=%b loads=%0d expected first load 200", ok, loadDac.size());
    end
    nCmp++;
    if (usbQ != expUsb) begin
      nMis++; $display("[TB] FAIL abort_restart_stream got %0d words expected %0d matching words", usbQ.size(), expUsb.size());
    end
    endSweep();
  endtask

  task automatic test_async_reset();
    clearLogs();
    scDelay = 3;
    enPct = 100;
    @(negedge Clk);
    StartDac = 10'd300; EndDac = 10'd305; DacStep = 10'd1; MaxWordCount = 16'd3;
    SweepStart = 1'b1;
    repeat (25) @(negedge Clk);
    #2 reset_n = 1'b0;
    #1;
    nCmp++;
    if ({SweepAcq10BitDac, SweepAcqMicrorocAcqStartStop, SweepAcqData_en,
         SweepTestUsbStartStop, SweepAcqDone} !== 14'd0) begin
      nMis++; $display("[TB] FAIL async_reset_outputs got dac=%0d acq=%b usb=%b expected all 0",
                       SweepAcq10BitDac, SweepAcqMicrorocAcqStartStop, SweepTestUsbStartStop);
    end
    @(negedge Clk);
    SweepStart = 1'b0;
    reset_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    nCmp++;
    if ({SweepAcqMicrorocSCParameterLoad, SweepTestUsbStartStop, SweepAcqDone} !== 3'b000) begin
      nMis++; $display("[TB] FAIL async_reset_idle got load=%b usb=%b done=%b expected 000",
                       SweepAcqMicrorocSCParameterLoad, SweepTestUsbStartStop, SweepAcqDone);
    end
  endtask

  task automatic test_random_sweeps();
    bit ok;
    logic [9:0] s, e, st;
    logic [15:0] mx;
    for (int it = 0; it < 5; it++) begin
      s  = 10'($urandom_range(1023));
      e  = ($urandom_range(3) == 0 && s != 0) ? s - 10'd1
           : ((int'(s) + 8 > 1023) ? 10'd1023 : s + 10'($urandom_range(8)));
      st = 10'($urandom_range(3));
      mx = 16'($urandom_range(4));
      runSweep(s, e, st, mx, int'($urandom_range(1, 8)), int'($urandom_range(30, 100)), 1'b1, ok);
      buildExpected(s, e, st, mx);
      nCmp++;
      if (!ok) begin nMis++; $display("[TB] FAIL rand%0d_done got timeout expected SweepAcqDone=1", it); end
      nCmp++;
      if (loadDac != expLoad) begin
        nMis++; $display("[TB] FAIL rand%0d_loads got %0d loads expected %0d (s=%0d e=%0d st=%0d)",
                         it, loadDac.size(), expLoad.size(), s, e, st);
      end
      nCmp++;
      if (usbQ != expUsb) begin
        nMis++; $display("[TB] FAIL rand%0d_stream got %0d words expected %0d (mx=%0d)",
                         it, usbQ.size(), expUsb.size(), mx);
      end
      nCmp++;
      if (doneCyc.size() != expLoad.size()) begin
        nMis++; $display("[TB] FAIL rand%0d_single_done got %0d expected %0d", it, doneCyc.size(), expLoad.size());
      end
      endSweep();
    end
  endtask

  task automatic test_sc_timeout();
    bit ok;
    runSweep(10'd40, 10'd40, 10'd1, 16'd1, 0, 100, 1'b0, ok);
    nCmp++;
    if (!ok) begin nMis++; $display("[TB] FAIL timeout_done got timeout expected SweepAcqDone=1"); end
    nCmp++;
    if (usbCyc.size() == 0 || loadCyc.size() == 0 || usbCyc[0] - loadCyc[0] != 1001) begin
      nMis++; $display("[TB] FAIL timeout_header_latency got %0d expected 1001",
                       (usbCyc.size() > 0 && loadCyc.size() > 0) ? usbCyc[0] - loadCyc[0] : -1);
    end
    nCmp++;
    if (usbQ.size() != 3 || usbQ[2] !== TRAILER_WORD) begin
      nMis++; $display("[TB] FAIL timeout_stream got %0d words expected 3 ending %h", usbQ.size(), TRAILER_WORD);
    end
    endSweep();
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_reversed_range();
    test_top_of_range();
    test_continuous();
    test_abort();
    test_async_reset();
    test_random_sweeps();
    test_sc_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
